exec_controller: RTL and testbench

EXEC_CONTROLLER -- requirements
Module: exec_controller

---
 rtl/exec_controller.sv | 152 +++++++++++++++
 tb/tb_exec_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// exec_controller: four-state instruction sequencer for an external ALU.
// Holds a 16x16 register file, latches one instruction at a time, presents
// operands to the ALU, captures its result and retires into Rdest / psr.
module exec_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [15:0] alu_r1,
    output logic [15:0] alu_r2,
    output logic [7:0]  alu_opcode,
    output logic [7:0]  alu_flags_in,
    input  logic [15:0] alu_rout,
    input  logic [7:0]  alu_flags,
    output logic [7:0]  psr,
    output logic        done,
    output logic        err,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] instr_q;
    logic [15:0] alu_r1_q;
    logic [15:0] alu_r2_q;
    logic [7:0]  alu_op_q;
    logic [15:0] rout_q;
    logic [7:0]  flags_q;
    logic [7:0]  psr_q;
    logic        done_q;
    logic        err_q;
    logic        ready_q;

    // Register file read view, one element per architectural register.
    logic [15:0] rf_rd [16];

    // Decode of the latched instruction.
    logic [7:0]  op_d;
    logic        is_movi_d;
    logic        is_alu_d;
    logic        illegal_d;
    logic        wr_en_d;
    logic [3:0]  wr_addr_d;
    logic [15:0] wr_data_d;
    logic        psr_ld_d;

    // Classify the latched instruction and form the write-back controls.
    always_comb begin
        op_d      = instr_q[15:8];
        is_movi_d = (instr_q[15:12] == 4'hD);
        is_alu_d  = 1'b0;
        case (op_d)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84: is_alu_d = 1'b1;
            default:                                  is_alu_d = 1'b0;
        endcase
        illegal_d = !is_movi_d && !is_alu_d;
        // CMP only updates flags; everything else legal writes Rdest.
        wr_en_d   = (state_q == WB) &&
                    (is_movi_d || (is_alu_d && (op_d != 8'h0B)));
        wr_addr_d = is_movi_d ? instr_q[11:8] : instr_q[7:4];
        wr_data_d = is_movi_d ? {{8{instr_q[7]}}, instr_q[7:0]} : rout_q;
        psr_ld_d  = (state_q == WB) && !is_movi_d &&
                    ((op_d == 8'h05) || (op_d == 8'h09) || (op_d == 8'h0B));
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rf
            logic [15:0] r_q;
            // One register: cleared by reset, loaded on its write-back.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= 16'h0000;
                end else if (wr_en_d && (wr_addr_d == 4'(gi))) begin
                    r_q <= wr_data_d;
                end
            end
            assign rf_rd[gi] = r_q;
        end
    endgenerate

    // Sequencer: IDLE -> READ -> EXEC -> WB -> IDLE, all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= 16'h0000;
            alu_r1_q <= 16'h0000;
            alu_r2_q <= 16'h0000;
            alu_op_q <= 8'h00;
            rout_q   <= 16'h0000;
            flags_q  <= 8'h00;
            psr_q    <= 8'h00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // instr_ready is high throughout IDLE, so valid alone accepts.
                    if (instr_valid) begin
                        instr_q <= instr;
                        ready_q <= 1'b0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    alu_r1_q <= rf_rd[instr_q[3:0]];
                    alu_r2_q <= rf_rd[instr_q[7:4]];
                    alu_op_q <= instr_q[15:8];
                    state_q  <= EXEC;
                end
                EXEC: begin
                    rout_q  <= alu_rout;
                    flags_q <= alu_flags;
                    // Pulses are high for the single WB cycle.
                    done_q  <= 1'b1;
                    err_q   <= illegal_d;
                    state_q <= WB;
                end
                WB: begin
                    if (psr_ld_d) begin
                        psr_q <= flags_q;
                    end
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready  = ready_q;
    assign alu_r1       = alu_r1_q;
    assign alu_r2       = alu_r2_q;
    assign alu_opcode   = alu_op_q;
    assign alu_flags_in = psr_q;
    assign psr          = psr_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dbg_data     = rf_rd[dbg_addr];

endmodule

// File: tb/tb_exec_controller.sv
// Testbench for exec_controller: directed scenarios plus random instruction
// stream, scored against an architectural register-file model.
module tb_exec_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_r1;
    logic [15:0] alu_r2;
    logic [7:0]  alu_opcode;
    logic [7:0]  alu_flags_in;
    logic [15:0] alu_rout;
    logic [7:0]  alu_flags;
    logic [7:0]  psr;
    logic        done;
    logic        err;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    exec_controller dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .alu_r1       (alu_r1),
        .alu_r2       (alu_r2),
        .alu_opcode   (alu_opcode),
        .alu_flags_in (alu_flags_in),
        .alu_rout     (alu_rout),
        .alu_flags    (alu_flags),
        .psr          (psr),
        .done         (done),
        .err          (err),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] ins;
        logic        err;
        logic [3:0]  dest;
        logic [15:0] val;
        logic [7:0]  psr;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic phase;

    logic       sweep_mode;
    logic [3:0] dbg_sel_mon;
    logic [3:0] dbg_sel_stim;
    assign dbg_addr = sweep_mode ? dbg_sel_stim : dbg_sel_mon;

    // Architectural model state.
    logic [15:0] m_r [16];
    logic [7:0]  m_psr;

    logic [7:0] legal_ops [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                   8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84};

    // ALU behaviour: a = R[Rsrc] (r1), b = R[Rdest] (r2).
    function automatic void alu_ref(input logic [7:0] op, input logic [15:0] a,
                                    input logic [15:0] b, input logic cin,
                                    output logic [15:0] r, output logic [7:0] f);
        logic [16:0] s;
        s = '0;
        r = '0;
        case (op)
            8'h01: r = b & a;
            8'h02: r = b | a;
            8'h03: r = b ^ a;
            8'h04: r = ~a;
            8'h05, 8'h06: begin s = {1'b0, b} + {1'b0, a}; r = s[15:0]; end
            8'h07: begin s = {1'b0, b} + {1'b0, a} + {16'b0, cin}; r = s[15:0]; end
            8'h08: r = b >> a[3:0];
            8'h09, 8'h0B: begin s = {1'b0, b} - {1'b0, a}; r = s[15:0]; end
            8'h0C, 8'h84: r = b << a[3:0];
            8'h0F: r = $signed(b) >>> a[3:0];
            default: r = 16'h0000;
        endcase
        f = r[7:0] ^ 8'h5A;
        if (op == 8'h05) begin
            f = 8'h00;
            f[0] = s[16];
            f[5] = (a[15] == b[15]) && (r[15] != b[15]);
        end else if (op == 8'h09) begin
            f = 8'h00;
            f[0] = s[16];
            f[5] = (a[15] != b[15]) && (r[15] != b[15]);
        end else if (op == 8'h0B) begin
            f = 8'h00;
            f[6] = (a == b);
            f[2] = (b < a);
            f[7] = ($signed(b) < $signed(a));
        end
    endfunction

    // External ALU stand-in driven from the DUT's operand registers.
    always_comb alu_ref(alu_opcode, alu_r1, alu_r2, alu_flags_in[0], alu_rout, alu_flags);

    function automatic logic is_legal_op(input logic [7:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
        m_psr = 8'h00;
    endtask

    task automatic model_step(input logic [15:0] ins, output exp_t e);
        logic [15:0] res;
        logic [7:0]  fl;
        logic [7:0]  op;
        op = ins[15:8];
        e.ins = ins;
        e.err = 1'b0;
        if (ins[15:12] == 4'hD) begin
            e.dest = ins[11:8];
            m_r[ins[11:8]] = {{8{ins[7]}}, ins[7:0]};
        end else if (is_legal_op(op)) begin
            e.dest = ins[7:4];
            alu_ref(op, m_r[ins[3:0]], m_r[ins[7:4]], m_psr[0], res, fl);
            if (op != 8'h0B) m_r[ins[7:4]] = res;
            if (op == 8'h05 || op == 8'h09 || op == 8'h0B) m_psr = fl;
        end else begin
            e.dest = ins[7:4];
            e.err = 1'b1;
        end
        e.val = m_r[e.dest];
        e.psr = m_psr;
        e.acc = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse, checks write-back next cycle.
    initial begin
        phase = 1'b0;
        dbg_sel_mon = 4'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                phase = 1'b0;
            end else if (phase) begin
                chk("wb_value", {16'h0, dbg_data}, {16'h0, cur.val});
                chk("wb_psr", {24'h0, psr}, {24'h0, cur.psr});
                chk("done_width", {31'h0, done}, 32'h0);
                chk("err_width", {31'h0, err}, 32'h0);
                phase = 1'b0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", {31'h0, done}, 32'h0);
                end else begin
                    cur = sb.pop_front();
                    chk("err_flag", {31'h0, err}, {31'h0, cur.err});
                    chk("done_latency", cyc - cur.acc, 32'd2);
                    dbg_sel_mon = cur.dest;
                    phase = 1'b1;
                    $display("txn instr=%h dest=R%0d exp_val=%h exp_psr=%h err=%0d",
                             cur.ins, cur.dest, cur.val, cur.psr, cur.err);
                end
            end else if (err) begin
                chk("err_without_done", {31'h0, err}, 32'h0);
            end
        end
    end

    task automatic issue(input logic [15:0] ins);
        int n;
        exp_t e;
        n = 0;
        while (!instr_ready && n < 40) begin @(negedge clk); n++; end
        if (!instr_ready) begin
            chk("ready_timeout", {31'h0, instr_ready}, 32'h1);
            return;
        end
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk); #1;
        model_step(ins, e);
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        // Noise on the bus while busy must be ignored.
        instr = 16'($urandom);
        instr_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!instr_ready && n < 40) begin @(negedge clk); n++; end
        if (!instr_ready) chk("idle_timeout", {31'h0, instr_ready}, 32'h1);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        wait_idle();
        n = 0;
        #2;
        while ((sb.size() != 0 || phase) && n < 50) begin
            @(negedge clk); #2; n++;
        end
        if (sb.size() != 0 || phase) chk("drain_timeout", sb.size(), 32'h0);
    endtask

    task automatic peek(input logic [3:0] a, input logic [15:0] v, input string nm);
        sweep_mode = 1'b1;
        dbg_sel_stim = a;
        #1;
        chk(nm, {16'h0, dbg_data}, {16'h0, v});
        sweep_mode = 1'b0;
    endtask

    initial begin
        int lowcnt;
        int kind;
        exp_t e;
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        sweep_mode = 1'b0;
        dbg_sel_stim = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, instr_ready}, 32'h1);
        chk("rst_psr", {24'h0, psr}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_alu_r1", {16'h0, alu_r1}, 32'h0);
        chk("rst_alu_r2", {16'h0, alu_r2}, 32'h0);
        chk("rst_alu_op", {24'h0, alu_opcode}, 32'h0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) peek(4'(i), 16'h0000, "rst_reg");

        // ADD example
        issue(16'hD105); issue(16'hD203); issue(16'h0512);
        drain();
        peek(4'd1, 16'h0008, "add_r1");
        chk("add_psr", {24'h0, psr}, 32'h00);
        // RSH then ADD with overflow
        issue(16'hD5FF); issue(16'hD601); issue(16'h0856);
        drain();
        peek(4'd5, 16'h7FFF, "rsh_r5");
        issue(16'h0556);
        drain();
        peek(4'd5, 16'h8000, "addovf_r5");
        chk("addovf_psr", {24'h0, psr}, 32'h20);
        // Illegal instruction
        issue(16'hFF12);
        drain();
        peek(4'd1, 16'h0008, "illegal_r1");
        chk("illegal_psr", {24'h0, psr}, 32'h20);
        // CMP equal
        issue(16'hD709); issue(16'hD809); issue(16'h0B78);
        drain();
        peek(4'd7, 16'h0009, "cmp_r7");
        chk("cmp_psr", {24'h0, psr}, 32'h40);

        // Back-to-back with instr_valid held high
        instr_valid = 1'b1;
        instr = 16'h0512;
        @(posedge clk); #1;
        model_step(16'h0512, e); e.acc = cyc; sb.push_back(e);
        lowcnt = 0;
        @(negedge clk);
        while (!instr_ready && lowcnt < 10) begin lowcnt++; @(negedge clk); end
        @(posedge clk); #1;
        model_step(16'h0512, e); e.acc = cyc; sb.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_ready_low", lowcnt, 32'd3);
        drain();
        peek(4'd1, 16'h000E, "b2b_r1");

        // Reset during EXEC aborts the instruction
        instr_valid = 1'b1;
        instr = 16'h0512;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'h0, instr_ready}, 32'h1);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_psr", {24'h0, psr}, 32'h0);
        peek(4'd1, 16'h0000, "abort_r1");
        // Accept on the first edge after reset
        issue(16'hD3A5);
        drain();
        peek(4'd3, 16'hFFA5, "post_rst_movi");

        // Random stream
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 99);
            if (kind < 30)
                issue({4'hD, 4'($urandom), 8'($urandom)});
            else if (kind < 85)
                issue({legal_ops[$urandom_range(0, 12)], 4'($urandom), 4'($urandom)});
            else
                issue(16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain();
        for (int i = 0; i < 16; i++) peek(4'(i), m_r[i], "final_reg");
        chk("final_psr", {24'h0, psr}, {24'h0, m_psr});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
